// File: rtl/rr_arb_mux_pkg.sv
// Shared helpers for the arbitrating mux and related arbiters.
package rr_arb_mux_pkg;

    // Ceiling log2, usable in parameter/localparam expressions.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // One-hot (up to 16 wide) to binary index; zero input yields index 0.
    function automatic logic [3:0] onehot2idx(input logic [15:0] oh);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (oh[i]) r = r | 4'(i);
        return r;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// Handshake bundle between N input streams and the merged output stream.
interface rr_arb_mux_if #(
    parameter int NUM_IN    = 4,
    parameter int BIT_WIDTH = 32
);
    localparam int SEL_WIDTH = rr_arb_mux_pkg::clog2(NUM_IN);

    logic [NUM_IN-1:0]           in_valid;
    logic [NUM_IN*BIT_WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]           in_last;
    logic [NUM_IN-1:0]           in_ready;
    logic                        out_valid;
    logic [BIT_WIDTH-1:0]        out_data;
    logic                        out_last;
    logic [SEL_WIDTH-1:0]        out_sel;
    logic                        out_ready;

    // Seen from the mux: consumes the input streams, produces the output stream.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );

    // Seen from the environment driving the inputs and draining the output.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// Round-robin arbiter with optional packet lock. Grant is combinational;
// the rotation pointer and lock state advance only on an accepted beat.
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    localparam int SEL_WIDTH = clog2(NUM_IN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IN-1:0]    req,
    input  logic                 advance,  // granted beat accepted this cycle
    input  logic                 lock,     // accepted beat opens/continues a packet
    output logic [NUM_IN-1:0]    gnt,
    output logic [SEL_WIDTH-1:0] gnt_idx
);

    logic [SEL_WIDTH-1:0] ptr;
    logic                 locked;
    logic [SEL_WIDTH-1:0] lock_ch;
    logic [NUM_IN-1:0]    srch;
    logic                 found;
    logic [SEL_WIDTH-1:0] idx;

    // First requester after ptr, wrapping modulo NUM_IN; never touches indices >= NUM_IN.
    always_comb begin
        srch  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_IN; k++) begin
            idx = SEL_WIDTH'((int'(ptr) + k) % NUM_IN);
            if (!found && req[idx]) begin
                srch[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

    // A held packet pins the grant to its channel even when that channel idles.
    always_comb begin
        gnt = srch;
        if (locked) begin
            gnt          = '0;
            gnt[lock_ch] = 1'b1;
        end
    end

    assign gnt_idx = SEL_WIDTH'(onehot2idx(16'(gnt)));

    // Rotate priority to just past the last winner; track packet ownership.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= SEL_WIDTH'(NUM_IN - 1);
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (advance) begin
            ptr    <= gnt_idx;
            locked <= lock;
            if (lock) lock_ch <= gnt_idx;
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// N-input round-robin arbitrating mux with a registered output stage.
// One beat per cycle when downstream keeps out_ready high.
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_IN    = 4,
    parameter int LOCK_EN   = 1
) (
    input  logic         clk,
    input  logic         rst,
    rr_arb_mux_if.slave  bus
);

    localparam int SEL_WIDTH = clog2(NUM_IN);

    logic [NUM_IN-1:0][BIT_WIDTH-1:0] ch_data;
    logic [NUM_IN-1:0]                gnt;
    logic [SEL_WIDTH-1:0]             gnt_idx;
    logic                             free;
    logic                             any_v;
    logic                             xfer_in;
    logic                             lock;

    assign ch_data = bus.in_data;
    assign free    = !bus.out_valid || bus.out_ready;
    assign any_v   = |bus.in_valid;

    // Ready only goes to the granted channel, and never while in reset.
    assign bus.in_ready = (free && any_v && !rst) ? gnt : '0;
    assign xfer_in      = |(bus.in_valid & bus.in_ready);

    // Only a non-final beat holds the grant, and only when locking is built in.
    assign lock = (LOCK_EN != 0) && !bus.in_last[gnt_idx];

    rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.in_valid),
        .advance (xfer_in),
        .lock    (lock),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Output register: load on accept (replacing any beat leaving), clear when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_last  <= 1'b0;
            bus.out_sel   <= '0;
        end else if (xfer_in) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= ch_data[gnt_idx];
            bus.out_last  <= bus.in_last[gnt_idx];
            bus.out_sel   <= gnt_idx;
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench: locked 4-input, unlocked 4-input and 3-input instances.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_arb_mux_if #(.NUM_IN(4), .BIT_WIDTH(32)) ifa ();
    rr_arb_mux_if #(.NUM_IN(4), .BIT_WIDTH(32)) ifb ();
    rr_arb_mux_if #(.NUM_IN(3), .BIT_WIDTH(32)) ifc ();

    rr_arb_mux #(.BIT_WIDTH(32), .NUM_IN(4), .LOCK_EN(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    rr_arb_mux #(.BIT_WIDTH(32), .NUM_IN(4), .LOCK_EN(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    rr_arb_mux #(.BIT_WIDTH(32), .NUM_IN(3), .LOCK_EN(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifa.in_valid = '0; ifa.in_data = '0; ifa.in_last = '1; ifa.out_ready = 1'b1;
        ifb.in_valid = '0; ifb.in_data = '0; ifb.in_last = '1; ifb.out_ready = 1'b1;
        ifc.in_valid = '0; ifc.in_data = '0; ifc.in_last = '1; ifc.out_ready = 1'b1;

        // reset: ready forced low even with every channel valid
        ifa.in_valid = 4'b1111;
        tick(); tick();
        chk("rst_in_ready", ifa.in_ready, 4'b0000);
        chk("rst_out_valid", ifa.out_valid, 1'b0);
        chk("rst_out_data", ifa.out_data, 32'h0);
        chk("rst_out_sel", ifa.out_sel, 2'd0);
        chk("rst_out_last", ifa.out_last, 1'b0);
        rst = 1'b0;
        ifa.in_valid = 4'b0000;

        // single channel 2
        ifa.in_valid = 4'b0100;
        ifa.in_data[2*32 +: 32] = 32'hDEAD_BEEF;
        #1 chk("single_in_ready", ifa.in_ready, 4'b0100);
        tick();
        chk("single_out_valid", ifa.out_valid, 1'b1);
        chk("single_out_data", ifa.out_data, 32'hDEAD_BEEF);
        chk("single_out_sel", ifa.out_sel, 2'd2);
        ifa.in_valid = 4'b0000;
        #1 chk("idle_in_ready", ifa.in_ready, 4'b0000);
        tick();
        chk("drain_out_valid", ifa.out_valid, 1'b0);

        // backpressure: beat from ch1 held for 5 cycles
        ifa.in_data[1*32 +: 32] = 32'h1111_1111;
        ifa.in_data[2*32 +: 32] = 32'h2222_2222;
        ifa.in_data[3*32 +: 32] = 32'h3333_3333;
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 4'b0010;
        #1 chk("bp_first_ready", ifa.in_ready, 4'b0010);
        tick();
        ifa.in_valid = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("bp_ready%0d", i), ifa.in_ready, 4'b0000);
            chk($sformatf("bp_data%0d", i), ifa.out_data, 32'h1111_1111);
            chk($sformatf("bp_sel%0d", i), ifa.out_sel, 2'd1);
            tick();
        end
        ifa.out_ready = 1'b1;
        #1 chk("bp_release_ready", ifa.in_ready, 4'b0100);
        tick();
        chk("bp_next_sel", ifa.out_sel, 2'd2);
        chk("bp_next_data", ifa.out_data, 32'h2222_2222);
        ifa.in_valid = 4'b0000;
        tick();

        // lock: move ptr to 3 so ch0 is searched first
        ifa.in_valid = 4'b1000;
        tick();
        chk("lk_pre_sel", ifa.out_sel, 2'd3);
        ifa.in_valid = 4'b1001;
        ifa.in_last  = 4'b1110;
        ifa.in_data[0 +: 32] = 32'hA000_0000;
        #1 chk("lk_b0_ready", ifa.in_ready, 4'b0001);
        tick();
        chk("lk_b0_sel", ifa.out_sel, 2'd0);
        chk("lk_b0_last", ifa.out_last, 1'b0);
        ifa.in_data[0 +: 32] = 32'hA000_0001;
        #1 chk("lk_b1_ready", ifa.in_ready, 4'b0001);
        tick();
        chk("lk_b1_sel", ifa.out_sel, 2'd0);
        chk("lk_b1_data", ifa.out_data, 32'hA000_0001);
        ifa.in_valid = 4'b1000;
        #1 chk("lk_gap_ch3_ready", ifa.in_ready[3], 1'b0);
        tick();
        chk("lk_gap_bubble", ifa.out_valid, 1'b0);
        ifa.in_valid = 4'b1001;
        ifa.in_last  = 4'b1111;
        ifa.in_data[0 +: 32] = 32'hA000_0002;
        #1 chk("lk_b2_ready", ifa.in_ready, 4'b0001);
        tick();
        chk("lk_b2_sel", ifa.out_sel, 2'd0);
        chk("lk_b2_data", ifa.out_data, 32'hA000_0002);
        chk("lk_b2_last", ifa.out_last, 1'b1);
        ifa.in_valid = 4'b1000;
        #1 chk("lk_after_ready", ifa.in_ready, 4'b1000);
        tick();
        chk("lk_after_sel", ifa.out_sel, 2'd3);
        chk("lk_after_data", ifa.out_data, 32'h3333_3333);
        ifa.in_valid = 4'b0000;
        tick();

        // reset while locked on ch1 with a stalled beat
        ifa.out_ready = 1'b0;
        ifa.in_last   = 4'b1101;
        ifa.in_valid  = 4'b0010;
        #1 chk("rm_ready", ifa.in_ready, 4'b0010);
        tick();
        chk("rm_held", ifa.out_valid, 1'b1);
        rst = 1'b1;
        ifa.in_valid = 4'b0011;
        #1 chk("rm_rst_ready", ifa.in_ready, 4'b0000);
        tick();
        chk("rm_out_valid", ifa.out_valid, 1'b0);
        chk("rm_out_sel", ifa.out_sel, 2'd0);
        rst = 1'b0;
        ifa.out_ready = 1'b1;
        ifa.in_last   = 4'b1111;
        #1 chk("rm_release_ready", ifa.in_ready, 4'b0001);
        tick();
        chk("rm_release_sel", ifa.out_sel, 2'd0);
        ifa.in_valid = 4'b0000;
        tick();

        // fairness, no lock: in_last=0 must not hold the grant
        for (int i = 0; i < 4; i++) ifb.in_data[i*32 +: 32] = 32'hB000_0000 + i;
        ifb.in_last  = 4'b0000;
        ifb.in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("fair_valid%0d", i), ifb.out_valid, 1'b1);
            chk($sformatf("fair_sel%0d", i), ifb.out_sel, 64'(i % 4));
            chk($sformatf("fair_data%0d", i), ifb.out_data, 64'(32'hB000_0000 + (i % 4)));
            chk($sformatf("fair_last%0d", i), ifb.out_last, 1'b0);
        end
        ifb.in_valid = 4'b0000;
        tick();
        chk("fair_drain", ifb.out_valid, 1'b0);

        // 3-input instance: rotation wraps 0,1,2,0 and never shows 3
        for (int i = 0; i < 3; i++) ifc.in_data[i*32 +: 32] = 32'hC000_0000 + i;
        ifc.in_valid = 3'b111;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("n3_valid%0d", i), ifc.out_valid, 1'b1);
            chk($sformatf("n3_sel%0d", i), ifc.out_sel, 64'(i % 3));
            chk($sformatf("n3_data%0d", i), ifc.out_data, 64'(32'hC000_0000 + (i % 3)));
        end
        ifc.in_valid = 3'b000;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
